fu_issue_arbiter: RTL

- Shares one functional unit between NUM_REQ reservation-station requesters.
- Picks one ready instruction per cycle, round-robin, and returns a grant to the winner.
- Holds the winner in a single registered issue stage that drives the FU's control inputs: inst_id, inst, op, out_prn, pc, inst_valid.
- Stalls on FU back-pressure and drops the staged instruction on pipeline flush.

---
 rtl/fu_issue_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/fu_issue_arbiter.sv
// fu_issue_arbiter: round-robin arbiter that selects one ready reservation-station
// entry per cycle and stages it in a single registered issue slot feeding one FU.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               empty the issue stage and suppress grants this cycle
//   req_valid           per-requester ready flag (bit i = requester i)
//   req_inst_id/inst/op/out_prn/pc   per-requester instruction payload
//   req_grant           combinational one-hot grant; the winner is captured this edge
//   fu_ready            FU accepts the staged instruction this cycle
//   iss_*               registered issue stage driving the FU control inputs
//   iss_valid           staged instruction valid (FU inst_valid)
module fu_issue_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned INST_ID_BITS = 6,
  parameter int unsigned PRN_BITS     = 6,
  parameter int unsigned MAX_OPERANDS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [INST_ID_BITS-1:0] req_inst_id [NUM_REQ],
  input  logic [31:0]             req_inst    [NUM_REQ],
  input  logic [63:0]             req_op      [NUM_REQ][MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     req_out_prn [NUM_REQ][MAX_OPERANDS],
  input  logic [63:0]             req_pc      [NUM_REQ],
  output logic [NUM_REQ-1:0]      req_grant,
  input  logic                    fu_ready,
  output logic [INST_ID_BITS-1:0] iss_inst_id,
  output logic [31:0]             iss_inst,
  output logic [63:0]             iss_op      [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     iss_out_prn [MAX_OPERANDS],
  output logic [63:0]             iss_pc,
  output logic                    iss_valid
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] ptr_next;
  logic             found;
  logic             load_en;
  logic             grant_any;

  // Stage can accept a new instruction when empty or draining to the FU this cycle.
  assign load_en   = !rst && !flush && (!iss_valid || fu_ready);
  assign grant_any = load_en && found;

  // Rotating priority search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  // Pointer advances past the winner; explicit wrap keeps non-power-of-two sizes correct.
  always_comb begin
    ptr_next = rr_ptr;
    if (32'(win) == NUM_REQ - 1) ptr_next = '0;
    else                         ptr_next = win + PTR_W'(1);
  end

  // One-hot grant, only when the stage will actually capture the winner.
  always_comb begin
    req_grant = '0;
    if (grant_any) req_grant[win] = 1'b1;
  end

  // Issue stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid   <= 1'b0;
      iss_inst_id <= '0;
      iss_inst    <= '0;
      iss_pc      <= '0;
      for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
        iss_op[j]      <= '0;
        iss_out_prn[j] <= '0;
      end
      rr_ptr <= '0;
    end else if (load_en) begin
      if (found) begin
        iss_valid   <= 1'b1;
        iss_inst_id <= req_inst_id[win];
        iss_inst    <= req_inst[win];
        iss_pc      <= req_pc[win];
        for (int unsigned j = 0; j < MAX_OPERANDS; j++) begin
          iss_op[j]      <= req_op[win][j];
          iss_out_prn[j] <= req_out_prn[win][j];
        end
        rr_ptr <= ptr_next;
      end else begin
        // Nothing ready: stage empties, payload left stale.
        iss_valid <= 1'b0;
      end
    end else if (flush) begin
      iss_valid <= 1'b0;
    end
  end

endmodule
